// File: rtl/apb_arb_pkg.sv
// Shared types for the multi-requester APB master: FSM states, latched
// request record and watchdog counter sizing.
package apb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   // Fields are sized for the widest supported bus; narrower instances zero-extend.
   localparam int REQ_FIELD_W = 64;

   typedef struct packed {
      logic                   write;
      logic [REQ_FIELD_W-1:0] addr;
      logic [REQ_FIELD_W-1:0] wdata;
   } apb_req_t;

   localparam int TIMEOUT_CYC_DEF = 16;
   localparam int TO_CNT_W_DEF    = $clog2(TIMEOUT_CYC_DEF);

   function automatic int to_cnt_w(input int timeout_cyc);
      return (timeout_cyc < 2) ? 1 : $clog2(timeout_cyc);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid request at or above ptr,
// wrapping, as a one-hot grant plus its index.
module rr_arbiter #(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_any
);

   int unsigned cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = (int'(ptr) + i) % NUM_REQ;
         if (!grant_any && req[cand]) begin
            grant[cand] = 1'b1;
            grant_idx   = IDX_W'(cand);
            grant_any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_master_arb.sv
// APB master shared by NUM_REQ requesters: round-robin grant, one transfer
// at a time, PREADY wait states and a watchdog that aborts hung ACCESS phases.
//
// state  | meaning
// IDLE   | bus idle; grant a valid requester and latch its request
// SETUP  | PSEL=1, PENABLE=0 for one cycle; watchdog cleared
// ACCESS | PSEL=PENABLE=1 until PREADY or watchdog expiry
module apb_master_arb
   import apb_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int NUM_REQ     = 2,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                      PCLK,
   input  logic                      PRESETn,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic                      rsp_timeout,
   output logic                      PSEL,
   output logic                      PENABLE,
   output logic                      PWRITE,
   output logic [ADDR_W-1:0]         PADDR,
   output logic [DATA_W-1:0]         PWDATA,
   input  logic [DATA_W-1:0]         PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   localparam int              IDX_W    = $clog2(NUM_REQ);
   localparam int              CNT_W    = to_cnt_w(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   apb_state_t         state, state_nxt;
   apb_req_t           lat_req;
   logic [IDX_W-1:0]   rr_ptr, lat_idx, arb_idx;
   logic [NUM_REQ-1:0] arb_grant;
   logic               arb_any;
   logic [CNT_W-1:0]   to_cnt;
   logic               accept, xfer_done, xfer_abort;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .grant_any (arb_any)
   );

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      xfer_done  = 1'b0;
      xfer_abort = 1'b0;
      req_ready  = '0;
      PSEL       = 1'b0;
      PENABLE    = 1'b0;
      unique case (state)
         IDLE: begin
            if (arb_any) begin
               accept    = 1'b1;
               req_ready = arb_grant;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            PSEL      = 1'b1;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
            // PREADY on the last watchdog cycle still completes normally
            if (PREADY) begin
               xfer_done = 1'b1;
               state_nxt = IDLE;
            end else if (to_cnt == CNT_LAST) begin
               xfer_abort = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         lat_req     <= '0;
         lat_idx     <= '0;
         rr_ptr      <= '0;
         to_cnt      <= '0;
         rsp_valid   <= '0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         rsp_valid <= '0;
         if (accept) begin
            lat_req.write <= req_write[arb_idx];
            lat_req.addr  <= REQ_FIELD_W'(req_addr[arb_idx*ADDR_W +: ADDR_W]);
            lat_req.wdata <= REQ_FIELD_W'(req_wdata[arb_idx*DATA_W +: DATA_W]);
            lat_idx       <= arb_idx;
            rr_ptr        <= IDX_W'((int'(arb_idx) + 1) % NUM_REQ);
         end
         if (state == SETUP)
            to_cnt <= '0;
         else if (state == ACCESS && !PREADY && !xfer_abort)
            to_cnt <= to_cnt + 1'b1;
         if (xfer_done || xfer_abort) begin
            rsp_valid   <= NUM_REQ'(1) << lat_idx;
            rsp_err     <= xfer_abort | PSLVERR;
            rsp_timeout <= xfer_abort;
            rsp_rdata   <= (xfer_done && !lat_req.write) ? PRDATA : '0;
         end
      end
   end

   assign PWRITE = lat_req.write;
   assign PADDR  = ADDR_W'(lat_req.addr);
   assign PWDATA = DATA_W'(lat_req.wdata);

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed plus randomized bench for apb_master_arb; a transaction-level
// model predicts grants, bus phases and responses from the protocol rules.
module tb_apb_master_arb;

   localparam int NR = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic             PCLK    = 1'b0;
   logic             PRESETn = 1'b0;
   logic [NR-1:0]    req_valid, req_write, req_ready, rsp_valid;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_wdata;
   logic [DW-1:0]    rsp_rdata, PWDATA, PRDATA;
   logic [AW-1:0]    PADDR;
   logic             rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

   int            n_asrt = 0;
   int            n_fail = 0;
   int            m_ptr  = 0;
   logic [DW-1:0] last_rd;
   logic          last_err, last_to;

   always #5 PCLK = ~PCLK;

   apb_master_arb #(.ADDR_W(AW), .DATA_W(DW), .NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   function automatic int pick(input logic [NR-1:0] v, input int ptr);
      for (int i = 0; i < NR; i++)
         if (v[(ptr + i) % NR]) return (ptr + i) % NR;
      return -1;
   endfunction

   function automatic logic [NR-1:0] onehot(input int i);
      logic [NR-1:0] r;
      r    = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge PCLK);
      @(negedge PCLK);
   endtask

   // Caller sets requests in an IDLE cycle; returns in the response cycle.
   task automatic run_xfer(input bit keep, input int waits, input logic slverr,
                           input logic [DW-1:0] prd, output int g);
      logic [AW-1:0] ea;
      logic [DW-1:0] ew, erd;
      logic          ewr, eto;
      int            n_acc;
      #1;
      g = pick(req_valid, m_ptr);
      if (g < 0) begin
         n_asrt++;
         n_fail++;
         $error("FAIL pick_none: observed no valid request expected at least one");
         return;
      end
      chk("accept_ready", 64'(req_ready), 64'(onehot(g)));
      chk("accept_psel", 64'(PSEL), 64'd0);
      ea    = req_addr[g*AW +: AW];
      ew    = req_wdata[g*DW +: DW];
      ewr   = req_write[g];
      m_ptr = (g + 1) % NR;
      eto   = (waits >= TO);
      n_acc = eto ? TO : waits + 1;
      erd   = (eto || ewr) ? '0 : prd;

      step();
      if (!keep) req_valid = '0;
      req_addr  = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      req_write = NR'($urandom);
      PREADY    = 1'($urandom);
      PSLVERR   = 1'($urandom);
      PRDATA    = $urandom;
      #1;
      chk("setup_psel", 64'(PSEL), 64'd1);
      chk("setup_penable", 64'(PENABLE), 64'd0);
      chk("setup_paddr", 64'(PADDR), 64'(ea));
      chk("setup_pwrite", 64'(PWRITE), 64'(ewr));
      chk("setup_pwdata", 64'(PWDATA), 64'(ew));
      chk("setup_ready", 64'(req_ready), 64'd0);
      chk("setup_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("hold_rdata", 64'(rsp_rdata), 64'(last_rd));
      chk("hold_err", 64'(rsp_err), 64'(last_err));
      chk("hold_timeout", 64'(rsp_timeout), 64'(last_to));

      for (int k = 0; k < n_acc; k++) begin
         step();
         if (k < waits) begin
            PREADY  = 1'b0;
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom);
         end else begin
            PREADY  = 1'b1;
            PRDATA  = prd;
            PSLVERR = slverr;
         end
         #1;
         chk("access_psel", 64'(PSEL), 64'd1);
         chk("access_penable", 64'(PENABLE), 64'd1);
         chk("access_paddr", 64'(PADDR), 64'(ea));
         chk("access_pwrite", 64'(PWRITE), 64'(ewr));
         chk("access_pwdata", 64'(PWDATA), 64'(ew));
         chk("access_ready", 64'(req_ready), 64'd0);
         chk("access_rsp_valid", 64'(rsp_valid), 64'd0);
      end

      step();
      PREADY  = 1'($urandom);
      PSLVERR = 1'($urandom);
      PRDATA  = $urandom;
      #1;
      chk("rsp_psel", 64'(PSEL), 64'd0);
      chk("rsp_penable", 64'(PENABLE), 64'd0);
      chk("rsp_valid", 64'(rsp_valid), 64'(onehot(g)));
      chk("rsp_err", 64'(rsp_err), 64'(eto | slverr));
      chk("rsp_timeout", 64'(rsp_timeout), 64'(eto));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(erd));
      last_rd  = erd;
      last_err = eto | slverr;
      last_to  = eto;
   endtask

   initial begin
      int            g;
      int            w;
      logic [NR-1:0] vm;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      PRDATA    = '0;
      PREADY    = 1'b0;
      PSLVERR   = 1'b0;
      last_rd   = '0;
      last_err  = 1'b0;
      last_to   = 1'b0;

      repeat (2) @(negedge PCLK);
      #1;
      chk("rst_psel", 64'(PSEL), 64'd0);
      chk("rst_penable", 64'(PENABLE), 64'd0);
      chk("rst_pwrite", 64'(PWRITE), 64'd0);
      chk("rst_paddr", 64'(PADDR), 64'd0);
      chk("rst_pwdata", 64'(PWDATA), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rdata", 64'(rsp_rdata), 64'd0);
      chk("rst_err", 64'(rsp_err), 64'd0);
      chk("rst_timeout", 64'(rsp_timeout), 64'd0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      step();

      // single write from requester 0
      req_valid = 2'b01;
      req_write = 2'b01;
      req_addr[AW-1:0]  = 32'h14;
      req_wdata[DW-1:0] = 32'hDEAD_BEEF;
      run_xfer(1'b0, 0, 1'b0, 32'h0, g);

      // read from requester 1 with three wait states
      req_valid = 2'b10;
      req_write = 2'b00;
      req_addr[2*AW-1:AW] = 32'h08;
      run_xfer(1'b0, 3, 1'b0, 32'h0000_00A5, g);

      // both requesters held valid: back-to-back alternation
      req_valid = 2'b11;
      req_write = 2'b10;
      req_addr  = {32'h200, 32'h100};
      for (int i = 0; i < 4; i++) begin
         #1 chk("fair_order", 64'(req_ready), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
         run_xfer(1'b1, i % 3, 1'b0, $urandom, g);
      end
      req_valid = '0;

      // slave error on a read
      step();
      req_valid = 2'b01;
      req_write = 2'b00;
      req_addr[AW-1:0] = 32'h40;
      run_xfer(1'b0, 1, 1'b1, 32'hCAFE_0040, g);

      // watchdog abort, then PREADY on the final counted cycle
      req_valid = 2'b01;
      req_write = 2'b00;
      run_xfer(1'b0, TO, 1'b0, 32'h1234_5678, g);
      req_valid = 2'b10;
      req_write = 2'b00;
      run_xfer(1'b0, TO - 1, 1'b0, 32'h0000_55AA, g);
      req_valid = 2'b01;
      req_write = 2'b01;
      run_xfer(1'b0, TO + 1, 1'b1, 32'hFFFF_FFFF, g);

      for (int t = 0; t < 40; t++) begin
         vm        = NR'($urandom_range(1, (1 << NR) - 1));
         req_valid = vm;
         req_write = NR'($urandom);
         req_addr  = {$urandom, $urandom};
         req_wdata = {$urandom, $urandom};
         w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 2, TO + 1))
                                         : int'($urandom_range(0, 3));
         run_xfer(1'($urandom), w, 1'($urandom), $urandom, g);
      end
      req_valid = '0;

      // reset during ACCESS after granting requester 0 (pointer moves to 1)
      step();
      req_valid = 2'b01;
      req_write = 2'b00;
      #1 chk("pre_rst_grant", 64'(req_ready), 64'd1);
      step();
      req_valid = '0;
      step();
      PREADY = 1'b0;
      #1 chk("pre_rst_access", 64'({PSEL, PENABLE}), 64'd3);
      #1 PRESETn = 1'b0;
      #1;
      chk("async_rst_psel", 64'(PSEL), 64'd0);
      chk("async_rst_penable", 64'(PENABLE), 64'd0);
      chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("async_rst_rdata", 64'(rsp_rdata), 64'd0);
      repeat (2) step();
      chk("in_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      PRESETn  = 1'b1;
      m_ptr    = 0;
      last_rd  = '0;
      last_err = 1'b0;
      last_to  = 1'b0;
      step();
      chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("post_rst_psel", 64'(PSEL), 64'd0);
      req_valid = 2'b11;
      req_write = 2'b01;
      req_addr  = {32'hB0, 32'hA0};
      req_wdata = {32'h2222_2222, 32'h1111_1111};
      #1 chk("post_rst_grant0", 64'(req_ready), 64'd1);
      run_xfer(1'b0, 0, 1'b0, 32'h0, g);
      step();
      chk("final_rsp_valid", 64'(rsp_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
